// File: rtl/keypad_scan_ctrl_if.sv
// Key-event valid/ready bundle between the keypad scanner and its consumer.
interface keypad_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce.
// Emits one key-code event per physical press on a valid/ready bundle.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 row,
    output logic [3:0]                 col,
    output logic                       key_held,
    output logic                       overrun,
    keypad_scan_ctrl_if.master         bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sync1_q;
    logic [3:0] row_s_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0] col_idx_q, col_idx_d;
    logic [3:0] cand_q, cand_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_held_q, key_held_d;
    logic       overrun_q, overrun_d;

    logic       sample;
    logic       pressed;
    logic [1:0] row_idx;
    logic       accept;
    logic [7:0] match_inc;

    assign sample  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign pressed = (row_s_q != 4'hf);

    // Lowest-numbered closed row wins when several keys are down.
    always_comb begin
        row_idx = 2'd3;
        if (!row_s_q[0])
            row_idx = 2'd0;
        else if (!row_s_q[1])
            row_idx = 2'd1;
        else if (!row_s_q[2])
            row_idx = 2'd2;
    end

    always_comb begin
        div_cnt_d = sample ? '0 : div_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        key_held_d  = key_held_q;
        overrun_d   = 1'b0;
        accept      = 1'b0;
        match_inc   = match_cnt_q + 8'd1;

        if (key_valid_q && bus.key_ready)
            key_valid_d = 1'b0;

        if (sample) begin
            unique case (state_q)
                SCAN: begin
                    if (pressed) begin
                        cand_d      = {row_idx, col_idx_q};
                        match_cnt_d = 8'd1;
                        if (DEBOUNCE_CNT == 1)
                            accept = 1'b1;
                        else
                            state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (pressed && row_idx == cand_q[3:2]) begin
                        match_cnt_d = match_inc;
                        if (match_inc == 8'(DEBOUNCE_CNT))
                            accept = 1'b1;
                    end else begin
                        state_d     = SCAN;
                        col_idx_d   = col_idx_q + 2'd1;
                        match_cnt_d = 8'd0;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        match_cnt_d = match_inc;
                        if (match_inc == 8'(DEBOUNCE_CNT)) begin
                            state_d     = SCAN;
                            key_held_d  = 1'b0;
                            col_idx_d   = col_idx_q + 2'd1;
                            match_cnt_d = 8'd0;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        // A still-pending, unaccepted event blocks the new one.
        if (accept) begin
            state_d     = HELD;
            key_held_d  = 1'b1;
            match_cnt_d = 8'd0;
            if (key_valid_q && !bus.key_ready) begin
                overrun_d = 1'b1;
            end else begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            sync1_q     <= 4'hf;
            row_s_q     <= 4'hf;
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            cand_q      <= 4'd0;
            match_cnt_q <= 8'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= row;
            row_s_q     <= sync1_q;
            div_cnt_q   <= div_cnt_d;
            col_idx_q   <= col_idx_d;
            cand_q      <= cand_d;
            match_cnt_q <= match_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col           = ~(4'b0001 << col_idx_q);
    assign key_held      = key_held_q;
    assign overrun       = overrun_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer and debouncer for the 4x4 matrix keypad. Drives one-hot active-low column strobes at a programmable dwell rate and synchronizes the row returns. Each keypress is debounced and reported once as a 4-bit key-code event on a valid/ready handshake, so downstream display or command logic sees exactly one event per physical press.

Parameters:
SCAN_DIV, 50000, clock cycles per column dwell and per debounce sample period (1 ms at 50 MHz); legal range >= 4.
DEBOUNCE_CNT, 10, consecutive matching samples needed to accept a press or a release; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
row  input  4  keypad row returns, active-low (0 = key closed), asynchronous to clk.
col  output  4  column strobes, active-low, exactly one bit low at all times.
key_code  output  4  code of the accepted key: row_idx*4 + col_idx (0..15).
key_valid  output  1  event pending; held until accepted.
key_ready  input  1  consumer accepts the event in any cycle with key_valid=1.
key_held  output  1  high while an accepted key is still down (HELD state).
overrun  output  1  one-cycle pulse when an event is dropped.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low.
- Reset (reset=0 at a clk edge): state=SCAN, col_idx=0, col=4'b1110, div_cnt=0, match_cnt=0, key_code=0, key_valid=0, key_held=0, overrun=0, both synchronizer stages=4'b1111.
- row passes through a 2-flop synchronizer (row_s). All decisions use row_s.
- div_cnt counts 0..SCAN_DIV-1 and wraps. The "sample cycle" is the cycle with div_cnt==SCAN_DIV-1. div_cnt runs in all states.
- col = ~(1<<col_idx). col changes only at the edge that ends a sample cycle.
- Row decode: row_idx is the lowest-numbered 0 bit of row_s; "pressed" means row_s != 4'b1111. If multiple keys are down, the lowest row index wins.
- SCAN:
  - On a sample with no press, col_idx increments mod 4 (0->1->2->3->0).
  - On a sample with a press, latch cand = {row_idx, col_idx}, set match_cnt=1, and freeze col_idx.
  - If DEBOUNCE_CNT==1, accept immediately (go to HELD). Otherwise go to DEBOUNCE.
- DEBOUNCE (col frozen):
  - On a sample whose decoded row_idx equals cand row and a press is present, increment match_cnt. When match_cnt reaches DEBOUNCE_CNT, accept and go to HELD.
  - On a sample with a mismatch or no press, go to SCAN with col_idx+1 mod 4. No event.
- Accept: at that edge, key_code<=cand, key_valid<=1, key_held<=1, match_cnt<=0.
- HELD (col frozen):
  - An all-high sample increments match_cnt. A pressed sample clears it.
  - When match_cnt reaches DEBOUNCE_CNT, go to SCAN: key_held<=0, col_idx+1 mod 4.
  - No new event is produced while in HELD.
- Handshake:
  - key_valid falls at the edge after a cycle with key_valid=1 and key_ready=1.
  - On an accept edge where key_valid=1 and key_ready=0: the new event is dropped, key_code is unchanged, and overrun=1 for one cycle.
  - On an accept edge where key_valid=1 and key_ready=1: the old event is consumed, the new code is loaded, key_valid stays 1, and there is no overrun.
  - key_code is stable while key_valid=1.
- Reset mid-operation (any state) forces the reset values at that edge. A pending event is discarded.
- Widths: div_cnt is $clog2(SCAN_DIV) bits. match_cnt is 8 bits.

Test Plan:
(Bench overrides: SCAN_DIV=4, DEBOUNCE_CNT=3.)
1. Reset held 2 cycles, row=1111 -> col=1110, key_valid=0, key_held=0. After release, col steps 1110->1101->1011->0111->1110 every 4 cycles.
2. row=1101 whenever col=1011 (key row1/col2) -> col freezes at 1011. After 3 matching samples (9 cycles after the first sample), key_code=6, key_valid=1, key_held=1. A key_ready=1 pulse drops key_valid the next cycle.
3. Bounce: row=1110 for one sample only, during col=1110 -> no key_valid; the next column driven is 1101.
4. Release after test 2: row=1111 for 3 samples -> key_held falls, col advances to 0111. Holding the key for 20 samples yields exactly one event.
5. key_ready=0; press code 6, release, then press code 1 (row=1110, col=1101) -> key_code stays 6, overrun pulses exactly 1 cycle at the second accept.
6. Press key 0, assert reset during DEBOUNCE -> col=1110, no key_valid, key_held=0. After reset release, normal scan resumes.
